instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: the maximum number of cycles the block waits for read data before aborting.
REQ-003 clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 fetch_start  input  1  one-cycle request from the control FSM to fetch the instruction at the current PC.
REQ-006 pc_we, pc_next  input  1, 32  load strobe and value for the PC register.
REQ-007 mem_req, mem_addr  output  1, 32  memory read request and word address.
REQ-008 mem_gnt  input  1  memory has accepted the request.
REQ-009 mem_rvalid, mem_rdata  input  1, 32  read-data valid strobe and read data.
REQ-010 ir_we, ir_pc, ir_instr  output  1, 32, 32  write port that drives the downstream instruction register.
REQ-011 pc  output  32  current PC.
REQ-012 busy, fetch_done, fault_misalign, fault_timeout  output  1 each  status signals; all except busy are one-cycle pulses.

Function
REQ-013 The block SHALL implement the FSM states IDLE, REQ, WAIT; busy SHALL be high exactly when the state is not IDLE.
REQ-014 In IDLE, pc_we SHALL load pc_next into pc on the next edge; in REQ and WAIT, pc_we SHALL be ignored.
REQ-015 In IDLE, fetch_start SHALL latch the fetch address: pc_next if pc_we is also high, otherwise pc.
  - If the latched address has bits [1:0] == 0, the FSM SHALL enter REQ.
  - If the latched address has bits [1:0] != 0, the block SHALL pulse fault_misalign for one cycle, SHALL NOT assert mem_req, and SHALL stay in IDLE.
REQ-016 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal the latched address, both held stable until mem_gnt.
  - mem_gnt alone SHALL move the FSM to WAIT.
  - mem_gnt together with mem_rvalid SHALL complete the fetch in that same cycle (see REQ-017).
REQ-017 A fetch completes on mem_rvalid in WAIT. On the next edge the block SHALL:
  - drive ir_we = 1 for exactly one cycle, with ir_pc = latched address and ir_instr = mem_rdata captured at mem_rvalid;
  - pulse fetch_done in the same cycle as ir_we;
  - return the FSM to IDLE.
REQ-018 Fetch latency from fetch_start to ir_we with a zero-wait memory (mem_gnt and mem_rvalid in the first REQ cycle) SHALL be 2 cycles.
REQ-019 The WAIT-cycle counter SHALL clear on entry to WAIT and increment every cycle in WAIT.
  - When the counter reaches TIMEOUT without mem_rvalid, the block SHALL pulse fault_timeout, return to IDLE, and SHALL NOT assert ir_we.
  - The counter width SHALL be clog2(TIMEOUT+1) bits, and the counter SHALL saturate rather than wrap.
REQ-020 fetch_start while busy SHALL be ignored.
REQ-021 mem_rvalid or mem_gnt received while in IDLE SHALL be ignored.
REQ-022 ir_pc and ir_instr SHALL hold their last values while ir_we is 0.
REQ-023 pc SHALL NOT auto-increment; the next PC is computed outside this block.

Reset
REQ-024 On rstn low, regardless of state or any outstanding transaction:
  - the FSM SHALL go to IDLE and pc SHALL become RESET_PC;
  - mem_addr, ir_pc, ir_instr and the counter SHALL become 0;
  - mem_req, ir_we, busy and all pulse outputs SHALL become 0.
REQ-025 A read response arriving after reset deasserts SHALL be ignored per REQ-021.

Structure
REQ-026 The FSM state encoding and the default RESET_PC and TIMEOUT values SHALL live in the shared CPU package.
REQ-027 The WAIT-state counter SHALL be a sub-module named fetch_timer, with clear, enable, saturating count and an expired output.
REQ-028 All outputs SHALL be registered, except mem_req and busy, which SHALL decode directly from state.

Verification
REQ-029 Reset, then pc_we with pc_next=32'h0000_0040, then fetch_start; the memory grants immediately and returns 32'h0010_0093 one cycle later. Required: ir_we pulses once with ir_pc=32'h40 and ir_instr=32'h0010_0093.
REQ-030 fetch_start and pc_we asserted in the same cycle with pc_next=32'h0000_0008. Required: mem_addr=32'h8; a zero-wait memory yields ir_we exactly 2 cycles after fetch_start.
REQ-031 pc=32'h0000_0006, then fetch_start. Required: fault_misalign pulses one cycle, mem_req stays 0, busy stays 0.
REQ-032 mem_gnt asserted, then mem_rvalid withheld for 16 cycles. Required: fault_timeout pulses, ir_we stays 0, FSM back in IDLE; a subsequent fetch succeeds.
REQ-033 rstn pulled low while in WAIT, then mem_rvalid arrives after release. Required: ir_we stays 0, pc=RESET_PC, busy=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared CPU fetch definitions: FSM encoding, default reset PC and read timeout.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEF_TIMEOUT  = 16;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_timer.sv
// Saturating wait counter for the fetch WAIT state; expired is high once the count equals MAX.
// Single-cycle clear has priority over enable; no backpressure.
module fetch_timer #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_C)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == MAX_C);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, single outstanding memory read, IR write port with fault pulses.
// fetch_start to ir_we is 2 cycles on a zero-wait memory; mem_req holds until mem_gnt, fetch_start ignored while busy.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_start,
  input  logic        pc_we,
  input  logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ir_we,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_instr,
  output logic [31:0] pc,
  output logic        busy,
  output logic        fetch_done,
  output logic        fault_misalign,
  output logic        fault_timeout
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic [31:0]  ir_instr_q, ir_instr_d;
  logic         ir_we_q, ir_we_d;
  logic         done_q, done_d;
  logic         misalign_q, misalign_d;
  logic         timeout_q, timeout_d;
  logic         tmr_clr, tmr_en, tmr_expired;
  logic [31:0]  fetch_addr;

  // A same-cycle PC load wins over the old PC as the fetch address.
  assign fetch_addr = pc_we ? pc_next : pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    ir_pc_d    = ir_pc_q;
    ir_instr_d = ir_instr_q;
    ir_we_d    = 1'b0;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pc_we) begin
          pc_d = pc_next;
        end
        if (fetch_start) begin
          addr_d = fetch_addr;
          if (is_word_aligned(fetch_addr)) begin
            state_d = ST_REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (mem_rvalid) begin
            ir_we_d    = 1'b1;
            done_d     = 1'b1;
            ir_pc_d    = addr_q;
            ir_instr_d = mem_rdata;
            state_d    = ST_IDLE;
          end else begin
            tmr_clr = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (mem_rvalid) begin
          ir_we_d    = 1'b1;
          done_d     = 1'b1;
          ir_pc_d    = addr_q;
          ir_instr_d = mem_rdata;
          state_d    = ST_IDLE;
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      ir_pc_q    <= '0;
      ir_instr_q <= '0;
      ir_we_q    <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      ir_pc_q    <= ir_pc_d;
      ir_instr_q <= ir_instr_d;
      ir_we_q    <= ir_we_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  fetch_timer #(
    .MAX (TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign mem_req        = (state_q == ST_REQ);
  assign busy           = (state_q != ST_IDLE);
  assign mem_addr       = addr_q;
  assign pc             = pc_q;
  assign ir_we          = ir_we_q;
  assign ir_pc          = ir_pc_q;
  assign ir_instr       = ir_instr_q;
  assign fetch_done     = done_q;
  assign fault_misalign = misalign_q;
  assign fault_timeout  = timeout_q;

endmodule
